pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: EX-stage operand forwarding, load-use stall,
// branch flush and a multi-cycle ALU wait FSM with a sticky timeout.
// Optional feature macro: HAZ_PERF_CNT_EN adds saturating stall/flush
// performance counters (StallCnt, FlushCnt).
module pipeline_hazard_ctrl #(
  parameter int MD_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic [1:0] ResultSrcE,
  input  logic       PCSrcE,
  input  logic       MdStartE,
  input  logic       MdDoneE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       BubbleM,
  output logic       MdBusy,
  output logic       MdTimeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
`endif
);

  localparam int CW = $clog2(MD_TIMEOUT + 1);

  typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           to_q, to_d;
  logic           load_use;
  logic           md_hold;
  logic           cnt_last;

  // Operand forwarding: Memory stage wins over Writeback, x0 never forwards.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)      ForwardAE = 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ForwardAE = 2'b01;
    if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)      ForwardBE = 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ForwardBE = 2'b01;
  end

  assign load_use = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
  assign cnt_last = (cnt_q == CW'(MD_TIMEOUT - 1));
  // A multi-cycle op that is not yet finished holds the front of the pipe,
  // including its issue cycle in RUN, so the op stays parked in Execute.
  assign md_hold  = (state_q == RUN) ? (MdStartE && !MdDoneE) : !MdDoneE;

  // Next state, wait counter and timeout flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    case (state_q)
      RUN: begin
        cnt_d = '0;
        if (MdStartE && !MdDoneE) state_d = MD_WAIT;
      end
      MD_WAIT: begin
        if (MdDoneE) begin
          state_d = RUN;
        end else if (cnt_last) begin
          state_d = RUN;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Stall/flush/bubble outputs; reset gates them combinationally so they
  // drop the moment rst falls, independent of the clock.
  always_comb begin
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    BubbleM = 1'b0;
    if (rst) begin
      if (md_hold) begin
        StallF  = 1'b1;
        StallD  = 1'b1;
        StallE  = 1'b1;
        BubbleM = 1'b1;
      end else if (state_q == RUN && PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (state_q == RUN && load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  assign MdBusy    = (state_q == MD_WAIT);
  assign MdTimeout = to_q;

  // FSM state, wait counter and sticky timeout registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallF && stall_cnt_q != 32'hFFFF_FFFF)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if ((FlushD || FlushE) && flush_cnt_q != 32'hFFFF_FFFF)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (MD_TIMEOUT = 8): a driver issues
// directed and random stimulus and queues the reference model's expectation;
// a monitor on the falling edge pops and compares.
module tb_pipeline_hazard_ctrl;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, MdStartE, MdDoneE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, FlushD, FlushE, BubbleM, MdBusy, MdTimeout;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  pipeline_hazard_ctrl #(.MD_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
    .MdDoneE(MdDoneE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD),
    .FlushE(FlushE), .BubbleM(BubbleM), .MdBusy(MdBusy), .MdTimeout(MdTimeout)
`ifdef HAZ_PERF_CNT_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww;
    logic [1:0] rse;
    logic       pcs, mds, mdd;
  } stim_t;

  typedef struct {
    logic [11:0] outs;  // {FA, FB, SF, SD, SE, FD, FE, BM, Busy, TO}
    int unsigned scnt, fcnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model state: are we waiting on a multi-cycle op, how many
  // wait cycles have elapsed, sticky timeout, and the perf totals.
  bit          m_wait;
  int          m_elapsed;
  bit          m_to;
  int unsigned m_scnt, m_fcnt;

  function automatic logic [1:0] fwd(logic [4:0] rs, stim_t s);
    if (s.rwm && s.rdm != 0 && s.rdm == rs) return 2'b10;
    if (s.rww && s.rdw != 0 && s.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic apply(input stim_t s);
    bit sf, sd, se, fd, fe, bm, lu, hold;
    exp_t e;
    @(posedge clk);
    #1;
    rst = s.rst; Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e;
    RdE = s.rde; RdM = s.rdm; RdW = s.rdw; RegWriteM = s.rwm; RegWriteW = s.rww;
    ResultSrcE = s.rse; PCSrcE = s.pcs; MdStartE = s.mds; MdDoneE = s.mdd;
    if (!s.rst) begin
      m_wait = 0; m_elapsed = 0; m_to = 0; m_scnt = 0; m_fcnt = 0;
    end
    {sf, sd, se, fd, fe, bm} = '0;
    lu   = (s.rse == 2'b01) && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
    hold = m_wait ? !s.mdd : (s.mds && !s.mdd);
    if (s.rst) begin
      if (hold) {sf, sd, se, bm} = 4'hF;
      else if (!m_wait && s.pcs) {fd, fe} = 2'b11;
      else if (!m_wait && lu) {sf, sd, fe} = 3'b111;
    end
    e.outs = {fwd(s.rs1e, s), fwd(s.rs2e, s), sf, sd, se, fd, fe, bm, m_wait, m_to};
    e.scnt = m_scnt;
    e.fcnt = m_fcnt;
    exp_q.push_back(e);
    // Advance the model to what holds after the coming rising edge.
    if (s.rst) begin
      if (sf) m_scnt++;
      if (fd || fe) m_fcnt++;
      if (!m_wait) begin
        if (s.mds && !s.mdd) begin m_wait = 1; m_elapsed = 0; end
      end else begin
        m_elapsed++;
        if (s.mdd) m_wait = 0;
        else if (m_elapsed == TO) begin m_wait = 0; m_to = 1; end
      end
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst:1'b1, rs1d:5'd0, rs2d:5'd0, rs1e:5'd0, rs2e:5'd0, rde:5'd0,
          rdm:5'd0, rdw:5'd0, rwm:1'b0, rww:1'b0, rse:2'b00, pcs:1'b0,
          mds:1'b0, mdd:1'b0};
    return s;
  endfunction

  function automatic stim_t rnd(bit waiting);
    stim_t s;
    s.rst  = ($urandom_range(0, 199) != 0);
    s.rs1d = 5'($urandom_range(0, 3)); s.rs2d = 5'($urandom_range(0, 3));
    s.rs1e = 5'($urandom_range(0, 3)); s.rs2e = 5'($urandom_range(0, 3));
    s.rde  = 5'($urandom_range(0, 3)); s.rdm  = 5'($urandom_range(0, 3));
    s.rdw  = 5'($urandom_range(0, 3));
    s.rwm  = 1'($urandom); s.rww = 1'($urandom);
    s.rse  = 2'($urandom);
    s.pcs  = ($urandom_range(0, 5) == 0);
    s.mds  = waiting ? 1'($urandom) : ($urandom_range(0, 9) == 0);
    s.mdd  = waiting ? ($urandom_range(0, 6) == 0) : ($urandom_range(0, 3) == 0);
    return s;
  endfunction

  // Monitor: compare the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cyc++;
        checks++;
        if ({ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
             BubbleM, MdBusy, MdTimeout} !== e.outs) begin
          errors++;
          $display("FAIL outs cyc=%0d got=%b expected=%b (FA FB SF SD SE FD FE BM BUSY TO)",
                   cyc, {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD,
                   FlushE, BubbleM, MdBusy, MdTimeout}, e.outs);
        end
`ifdef HAZ_PERF_CNT_EN
        checks++;
        if (StallCnt !== e.scnt || FlushCnt !== e.fcnt) begin
          errors++;
          $display("FAIL perfcnt cyc=%0d got=%0d/%0d expected=%0d/%0d",
                   cyc, StallCnt, FlushCnt, e.scnt, e.fcnt);
        end
`endif
      end
    end
  end

  // Driver: directed scenarios, then randomized traffic.
  initial begin
    stim_t s;
    m_wait = 0; m_elapsed = 0; m_to = 0; m_scnt = 0; m_fcnt = 0;
    s = idle(); s.rst = 0;
    rst = 0; Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0; MdStartE = 0; MdDoneE = 0;
    // Reset with hazards present on the inputs: outputs must stay quiet.
    s.pcs = 1; s.mds = 1; apply(s); apply(s);
    // Forwarding: Memory beats Writeback, then RdM=x0 falls back to Writeback.
    s = idle(); s.rdm = 5; s.rwm = 1; s.rdw = 5; s.rww = 1; s.rs1e = 5; apply(s);
    s.rdm = 0; apply(s);
    s.rs2e = 5; s.rs1e = 9; apply(s);
    // Load-use, then the same with RdE=x0.
    s = idle(); s.rse = 2'b01; s.rde = 7; s.rs2d = 7; apply(s);
    s.rde = 0; apply(s);
    // Three load-use stalls in a row.
    s.rde = 7; repeat (3) apply(s);
    // Branch priority over load-use.
    s.pcs = 1; apply(s);
    s = idle(); apply(s);
    // Multi-cycle op finishing 5 cycles after issue, branch pulse mid-wait.
    s = idle(); s.mds = 1; apply(s);
    apply(s); s.pcs = 1; apply(s); s.pcs = 0; apply(s); apply(s);
    s.mdd = 1; apply(s);
    s = idle(); apply(s); apply(s);
    // Issue and finish in the same cycle: no stall, no wait.
    s.mds = 1; s.mdd = 1; apply(s);
    s = idle(); apply(s);
    // Timeout: done never arrives; flag stays set afterwards.
    s.mds = 1; apply(s);
    s.mds = 0; repeat (TO + 4) apply(s);
    s.pcs = 1; apply(s); s.pcs = 0; apply(s);
    // Reset asserted in the middle of a wait.
    s.mds = 1; apply(s); apply(s); apply(s);
    s.rst = 0; apply(s);
    s = idle(); apply(s); apply(s);
    // Random traffic.
    for (int i = 0; i < 3000; i++) apply(rnd(m_wait));
    s = idle(); apply(s);
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
